// File: rtl/pwm_bank_pkg.sv
// Shared types and constants for the PWM bank: compare modes, parameter
// defaults and limits, and the counter bit-reverse used by dithered channels.
package pwm_bank_pkg;

   typedef enum logic {
      LINEAR = 1'b0,
      BITREV = 1'b1
   } cmp_mode_e;

   localparam int NCH_DEFAULT   = 4;
   localparam int NCH_MIN       = 1;
   localparam int NCH_MAX       = 8;
   localparam int WIDTH_DEFAULT = 6;
   localparam int WIDTH_MIN     = 4;
   localparam int WIDTH_MAX     = 10;

   // Reverses the low 'width' bits of value (bit k -> bit width-1-k); the
   // upper WIDTH_MAX-width bits of the result are zero.
   function automatic logic [WIDTH_MAX-1:0] bit_reverse(
      input logic [WIDTH_MAX-1:0] value,
      input int unsigned          width
   );
      logic [WIDTH_MAX-1:0] full;
      for (int k = 0; k < WIDTH_MAX; k++) begin
         full[k] = value[WIDTH_MAX-1-k];
      end
      return full >> (WIDTH_MAX - width);
   endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: shadow and active duty/mode, pending flag, and the
// registered compare against the shared counter.
module pwm_chan
   import pwm_bank_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ce,
   input  logic             i_wrap_step,
   input  logic [WIDTH-1:0] i_cnt,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_wmode,
   input  logic             i_wimm,
   output logic             o_pwm,
   output logic             o_pend
);

   logic [WIDTH-1:0]     r_duty_sh;
   logic [WIDTH-1:0]     r_duty_act;
   cmp_mode_e            r_mode_sh;
   cmp_mode_e            r_mode_act;
   logic                 r_pend;
   logic                 r_pwm;

   logic [WIDTH_MAX-1:0] w_cnt_ext;
   logic [WIDTH_MAX-1:0] w_cnt_rev;
   logic [WIDTH_MAX-1:0] w_cmp;
   logic [WIDTH_MAX-1:0] w_duty_ext;

   // Compare in the WIDTH_MAX domain; the upper bits of both operands are zero.
   assign w_cnt_ext  = WIDTH_MAX'(i_cnt);
   assign w_cnt_rev  = bit_reverse(w_cnt_ext, WIDTH);
   assign w_duty_ext = WIDTH_MAX'(r_duty_act);
   assign w_cmp      = (r_mode_act == BITREV) ? w_cnt_rev : w_cnt_ext;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_duty_sh  <= '0;
         r_duty_act <= '0;
         r_mode_sh  <= LINEAR;
         r_mode_act <= LINEAR;
         r_pend     <= 1'b0;
         r_pwm      <= 1'b0;
      end else begin
         if (i_ce) begin
            r_pwm <= (w_cmp < w_duty_ext);
         end
         // A write on the wrap edge owns the channel: an immediate write wins
         // over the transfer, a deferred one waits for the following wrap.
         if (i_we) begin
            r_duty_sh <= i_wdata;
            r_mode_sh <= cmp_mode_e'(i_wmode);
            if (i_wimm) begin
               r_duty_act <= i_wdata;
               r_mode_act <= cmp_mode_e'(i_wmode);
               r_pend     <= 1'b0;
            end else begin
               r_pend     <= 1'b1;
            end
         end else if (i_wrap_step && r_pend) begin
            r_duty_act <= r_duty_sh;
            r_mode_act <= r_mode_sh;
            r_pend     <= 1'b0;
         end
      end
   end

   assign o_pwm  = r_pwm;
   assign o_pend = r_pend;

endmodule

// File: rtl/pwm_bank.sv
// Bank of NCH PWM channels sharing one free-running counter, with a wrap
// pulse and per-channel write decode into shadow or active duty registers.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter  int NCH   = NCH_DEFAULT,
   parameter  int WIDTH = WIDTH_DEFAULT,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK,
   input  logic             nRESET,
   input  logic             CE,
   input  logic             WE,
   input  logic [CHW-1:0]   WSEL,
   input  logic [WIDTH-1:0] WDATA,
   input  logic             WMODE,
   input  logic             WIMM,
   output logic [NCH-1:0]   PWM,
   output logic [NCH-1:0]   PEND,
   output logic             WRAP
);

   if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
      $error("pwm_bank: NCH out of range");
   end
   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("pwm_bank: WIDTH out of range");
   end

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;
   logic             w_wrap_step;
   logic             w_sel_valid;
   logic [NCH-1:0]   w_we_ch;
   logic [NCH-1:0]   w_pwm;
   logic [NCH-1:0]   w_pend;

   // The step that ends a period: counter at its top value while enabled.
   assign w_wrap_step = CE && (r_cnt == CNT_MAX);

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_step;
         if (CE) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // WE is a single-cycle strobe with no backpressure: every WE edge is
   // accepted; a select beyond the last channel is dropped silently.
   assign w_sel_valid = (int'(WSEL) < NCH);

   always_comb begin
      w_we_ch = '0;
      for (int i = 0; i < NCH; i++) begin
         if (WE && w_sel_valid && (int'(WSEL) == i)) begin
            w_we_ch[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      pwm_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .i_clk       (CLK),
         .i_rst_n     (nRESET),
         .i_ce        (CE),
         .i_wrap_step (w_wrap_step),
         .i_cnt       (r_cnt),
         .i_we        (w_we_ch[g]),
         .i_wdata     (WDATA),
         .i_wmode     (WMODE),
         .i_wimm      (WIMM),
         .o_pwm       (w_pwm[g]),
         .o_pend      (w_pend[g])
      );
   end

   assign PWM  = w_pwm;
   assign PEND = w_pend;
   assign WRAP = r_wrap;

endmodule
